// File: rtl/bin2bcd_6dig_module.sv
// Sequential 20-bit binary to six-digit packed BCD converter (shift-add-3, one bit per clock).
// Optional macro LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF on output.
module bin2bcd_6dig_module #(
  parameter int unsigned         BIN_W   = 20,
  parameter int unsigned         DIGITS  = 6,
  parameter logic [BIN_W-1:0]    MAX_VAL = 20'd999999
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start_Sig,
  input  logic [BIN_W-1:0]      Bin_Data,
  output logic                  Busy_Sig,
  output logic                  Done_Sig,
  output logic                  Ovf_Sig,
  output logic [4*DIGITS-1:0]   Number_Sig
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q;
  logic [BIN_W-1:0]  bin_q;
  logic [BcdW-1:0]   bcd_q;
  logic [CntW-1:0]   cnt_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_out_q;
  logic [BcdW-1:0]   number_q;

  logic [BcdW-1:0]   bcd_adj;
  logic [BcdW-1:0]   bcd_d;
  logic [BIN_W-1:0]  bin_d;
  logic [BcdW-1:0]   number_d;
  logic              lead;

  // Add-3 correction followed by the shift, chained within a single cycle.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = {bcd_adj[BcdW-2:0], bin_q[BIN_W-1]};
    bin_d = {bin_q[BIN_W-2:0], 1'b0};
  end

  always_comb begin
    number_d = bcd_q;
    lead     = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    // Least significant digit is never blanked so zero still shows as "0".
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      if (lead && (bcd_q[4*i +: 4] == 4'd0)) begin
        number_d[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_out_q <= 1'b0;
      number_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= Start_Sig;
          if (Start_Sig) begin
            bin_q   <= (Bin_Data > MAX_VAL) ? MAX_VAL : Bin_Data;
            ovf_q   <= (Bin_Data > MAX_VAL);
            bcd_q   <= '0;
            cnt_q   <= CntW'(BIN_W - 1);
            state_q <= StShift;
          end
        end
        StShift: begin
          busy_q <= 1'b1;
          bcd_q  <= bcd_d;
          bin_q  <= bin_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q    <= 1'b1;
          done_q    <= 1'b1;
          number_q  <= number_d;
          ovf_out_q <= ovf_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Busy_Sig   = busy_q;
  assign Done_Sig   = done_q;
  assign Ovf_Sig    = ovf_out_q;
  assign Number_Sig = number_q;

endmodule

// File: tb/tb_bin2bcd_6dig_module.sv
// Self-checking bench for bin2bcd_6dig_module: directed corner values plus random conversions
// against a decimal-arithmetic reference model.
module tb_bin2bcd_6dig_module;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start_Sig = 1'b0;
  logic [19:0] Bin_Data = '0;
  logic        Busy_Sig;
  logic        Done_Sig;
  logic        Ovf_Sig;
  logic [23:0] Number_Sig;

  int tests  = 0;
  int failed = 0;

  bin2bcd_6dig_module dut (
    .CLK        (CLK),
    .RST        (RST),
    .Start_Sig  (Start_Sig),
    .Bin_Data   (Bin_Data),
    .Busy_Sig   (Busy_Sig),
    .Done_Sig   (Done_Sig),
    .Ovf_Sig    (Ovf_Sig),
    .Number_Sig (Number_Sig)
  );

  always #5 CLK = ~CLK;

  function automatic logic [23:0] model_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned p;
    int unsigned ndig;
    if (v > 999999) v = 999999;
    r = '0;
    p = 1;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    ndig = 1;
    p = 10;
    while (ndig < 6 && v >= p) begin
      ndig++;
      p = p * 10;
    end
    for (int d = 0; d < 6; d++) begin
      if (d >= int'(ndig)) r[4*d +: 4] = 4'hF;
    end
`else
    ndig = 0;
`endif
    return r;
  endfunction

  // One conversion from IDLE with a single-cycle Start pulse; prev is the result on display.
  task automatic convert(input logic [19:0] bin, input logic [23:0] prev, input string name);
    logic [23:0] exp_num;
    logic        exp_ovf;
    int          n;
    exp_num = model_bcd(int'(bin));
    exp_ovf = (bin > 20'd999999);
    @(negedge CLK);
    Start_Sig = 1'b1;
    Bin_Data  = bin;
    @(posedge CLK);
    #1;
    Start_Sig = 1'b0;
    Bin_Data  = 20'($urandom);
    tests++;
    if (Busy_Sig !== 1'b1) begin
      failed++;
      $display("FAIL %s busy_after_accept: got %b want 1", name, Busy_Sig);
    end
    n = 0;
    while (n < 40) begin
      @(posedge CLK);
      #1;
      n++;
      if (n == 10) begin
        tests++;
        if (Number_Sig !== prev || Busy_Sig !== 1'b1 || Done_Sig !== 1'b0) begin
          failed++;
          $display("FAIL %s mid_conversion: num=%h busy=%b done=%b want num=%h busy=1 done=0",
                   name, Number_Sig, Busy_Sig, Done_Sig, prev);
        end
      end
      if (Done_Sig === 1'b1) break;
    end
    tests++;
    if (n != 21) begin
      failed++;
      $display("FAIL %s latency: done after %0d edges want 21", name, n);
    end
    tests++;
    if (Number_Sig !== exp_num || Ovf_Sig !== exp_ovf || Busy_Sig !== 1'b1) begin
      failed++;
      $display("FAIL %s result: num=%h ovf=%b busy=%b want num=%h ovf=%b busy=1",
               name, Number_Sig, Ovf_Sig, Busy_Sig, exp_num, exp_ovf);
    end
    @(posedge CLK);
    #1;
    tests++;
    if (Done_Sig !== 1'b0 || Busy_Sig !== 1'b0 || Number_Sig !== exp_num) begin
      failed++;
      $display("FAIL %s after_done: done=%b busy=%b num=%h want 0 0 %h",
               name, Done_Sig, Busy_Sig, Number_Sig, exp_num);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      tests++;
      if (Number_Sig !== 24'h0 || Busy_Sig !== 1'b0 || Done_Sig !== 1'b0 || Ovf_Sig !== 1'b0)
      begin
        failed++;
        $display("FAIL reset_idle: num=%h busy=%b done=%b ovf=%b want all zero",
                 Number_Sig, Busy_Sig, Done_Sig, Ovf_Sig);
      end
    end
  endtask

  task automatic test_directed(inout logic [23:0] prev);
    logic [19:0] vals [6];
    vals = '{20'd123456, 20'd0, 20'd907, 20'd999999, 20'd1000000, 20'hFFFFF};
    foreach (vals[i]) begin
      convert(vals[i], prev, $sformatf("directed_%0d", vals[i]));
      prev = model_bcd(int'(vals[i]));
    end
  endtask

  task automatic test_random(inout logic [23:0] prev);
    logic [19:0] v;
    for (int i = 0; i < 12; i++) begin
      v = (i % 3 == 0) ? 20'($urandom) : 20'($urandom_range(999999, 0));
      convert(v, prev, $sformatf("random_%0d", v));
      prev = model_bcd(int'(v));
    end
  endtask

  task automatic test_ignore_start(inout logic [23:0] prev);
    int n;
    int dones;
    @(negedge CLK);
    Start_Sig = 1'b1;
    Bin_Data  = 20'd42;
    @(posedge CLK);
    #1;
    Start_Sig = 1'b0;
    n = 0;
    dones = 0;
    while (n < 60) begin
      if (n == 4) begin
        @(negedge CLK);
        Start_Sig = 1'b1;
        Bin_Data  = 20'd77;
      end
      @(posedge CLK);
      #1;
      n++;
      if (n == 5) Start_Sig = 1'b0;
      if (Done_Sig === 1'b1) begin
        dones++;
        tests++;
        if (n != 21 || Number_Sig !== model_bcd(42)) begin
          failed++;
          $display("FAIL ignore_start_done: edge=%0d num=%h want edge 21 num=%h",
                   n, Number_Sig, model_bcd(42));
        end
      end
    end
    tests++;
    if (dones != 1) begin
      failed++;
      $display("FAIL ignore_start_count: got %0d done pulses want 1", dones);
    end
    prev = model_bcd(42);
  endtask

  task automatic test_back_to_back(inout logic [23:0] prev);
    int n;
    int last;
    int dones;
    @(negedge CLK);
    Start_Sig = 1'b1;
    Bin_Data  = 20'd31415;
    n = 0;
    last = -1;
    dones = 0;
    while (n < 100 && dones < 3) begin
      @(posedge CLK);
      #1;
      n++;
      if (Done_Sig === 1'b1) begin
        dones++;
        tests++;
        if (Number_Sig !== model_bcd(31415) || (last >= 0 && n - last != 22)) begin
          failed++;
          $display("FAIL back_to_back: num=%h gap=%0d want num=%h gap=22",
                   Number_Sig, n - last, model_bcd(31415));
        end
        last = n;
      end
    end
    tests++;
    if (dones != 3) begin
      failed++;
      $display("FAIL back_to_back_count: got %0d done pulses want 3", dones);
    end
    @(negedge CLK);
    Start_Sig = 1'b0;
    n = 0;
    while (n < 40 && Busy_Sig !== 1'b0) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (Busy_Sig !== 1'b0) begin
      failed++;
      $display("FAIL back_to_back_drain: busy=%b want 0", Busy_Sig);
    end
    prev = model_bcd(31415);
  endtask

  task automatic test_reset_abort(inout logic [23:0] prev);
    int dones;
    convert(20'd123456, prev, "abort_prior");
    @(negedge CLK);
    Start_Sig = 1'b1;
    Bin_Data  = 20'd654321;
    @(posedge CLK);
    #1;
    Start_Sig = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    tests++;
    if (Number_Sig !== 24'h0 || Busy_Sig !== 1'b0 || Done_Sig !== 1'b0 || Ovf_Sig !== 1'b0) begin
      failed++;
      $display("FAIL reset_abort_immediate: num=%h busy=%b done=%b ovf=%b want all zero",
               Number_Sig, Busy_Sig, Done_Sig, Ovf_Sig);
    end
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge CLK);
      if (Done_Sig === 1'b1) dones++;
    end
    tests++;
    if (dones != 0 || Number_Sig !== 24'h0) begin
      failed++;
      $display("FAIL reset_abort_no_done: dones=%0d num=%h want 0 000000", dones, Number_Sig);
    end
    convert(20'd5, 24'h0, "after_abort_5");
    prev = model_bcd(5);
  endtask

  initial begin
    logic [23:0] prev;
    test_reset();
    prev = 24'h0;
    test_directed(prev);
    test_random(prev);
    test_ignore_start(prev);
    test_back_to_back(prev);
    test_reset_abort(prev);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
